// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PC/global-history hashed PHT of saturating
// counters, speculative history with mispredict repair, and a sequential table init.
module gshare_predictor #(
    parameter int GHR_WIDTH = 8,
    parameter int IDX_WIDTH = 10,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pred_valid,
    input  logic [31:0]          if1_pc,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic                 ready
);

    localparam int DEPTH = 1 << IDX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] WEAK_TAKEN = CTR_WIDTH'(1) << (CTR_WIDTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   init_ptr;
    logic [GHR_WIDTH-1:0]   spec_ghr;
    logic [CTR_WIDTH-1:0]   pht [DEPTH];

    logic [IDX_WIDTH-1:0]   lookup_idx;
    logic [IDX_WIDTH-1:0]   upd_idx;
    logic [CTR_WIDTH-1:0]   lookup_ctr;
    logic [CTR_WIDTH-1:0]   upd_ctr;
    logic [CTR_WIDTH-1:0]   upd_next;

    logic                   pht_we;
    logic [IDX_WIDTH-1:0]   pht_widx;
    logic [CTR_WIDTH-1:0]   pht_wdata;

    logic                   unused_bits;

    assign lookup_idx = if1_pc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(spec_ghr);
    assign upd_idx    = upd_pc[IDX_WIDTH+1:2] ^ IDX_WIDTH'(upd_ghr);
    assign lookup_ctr = pht[lookup_idx];
    assign upd_ctr    = pht[upd_idx];

    assign pred_taken = ready & lookup_ctr[CTR_WIDTH-1];
    assign pred_ghr   = spec_ghr;

    assign unused_bits = ^{if1_pc[31:IDX_WIDTH+2], if1_pc[1:0],
                           upd_pc[31:IDX_WIDTH+2], upd_pc[1:0], upd_ghr[GHR_WIDTH-1]};

    always_comb begin
        upd_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != '1)
                upd_next = upd_ctr + 1'b1;
        end else if (upd_ctr != '0) begin
            upd_next = upd_ctr - 1'b1;
        end
    end

    // Single write port shared by init sweep and training; reset suppresses both.
    always_comb begin
        pht_we    = 1'b0;
        pht_widx  = init_ptr;
        pht_wdata = WEAK_TAKEN;
        if (rst_n) begin
            if (state == INIT) begin
                pht_we = 1'b1;
            end else if (upd_valid) begin
                pht_we    = 1'b1;
                pht_widx  = upd_idx;
                pht_wdata = upd_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we)
            pht[pht_widx] <= pht_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
            spec_ghr <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (upd_valid && upd_mispredict)
                        spec_ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken};
                    else if (pred_valid)
                        spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_taken};
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized self-checking bench for gshare_predictor against a behavioural
// table/history model, plus literal checks of the documented scenarios.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] if1_pc = '0;
    logic        pred_taken;
    logic [7:0]  pred_ghr;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [7:0]  upd_ghr = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic        ready;

    int total = 0;
    int bad = 0;
    bit started = 0;

    // behavioural model
    int m_pht [1024];
    int m_ghr = 0;
    int m_init_cnt = 0;
    bit m_ready = 0;

    gshare_predictor #(.GHR_WIDTH(8), .IDX_WIDTH(10), .CTR_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .if1_pc(if1_pc),
        .pred_taken(pred_taken), .pred_ghr(pred_ghr), .upd_valid(upd_valid),
        .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic int hash(logic [31:0] pc, int g);
        return ((pc >> 2) % 1024) ^ g;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int v;
        bit pt;
        if (!rst_n) begin
            m_ready = 0;
            m_init_cnt = 0;
            m_ghr = 0;
        end else if (!m_ready) begin
            m_init_cnt++;
            if (m_init_cnt == 1024) begin
                foreach (m_pht[i]) m_pht[i] = 2;
                m_ready = 1;
            end
        end else begin
            pt = m_pht[hash(if1_pc, m_ghr)] >= 2;
            if (upd_valid) begin
                v = m_pht[hash(upd_pc, upd_ghr)];
                v = upd_taken ? ((v + 1 > 3) ? 3 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
                m_pht[hash(upd_pc, upd_ghr)] = v;
            end
            if (upd_valid && upd_mispredict)
                m_ghr = ((upd_ghr << 1) | upd_taken) & 255;
            else if (pred_valid)
                m_ghr = ((m_ghr << 1) | pt) & 255;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_ready", ready, m_ready);
            check("model_pred_ghr", pred_ghr, m_ghr);
            check("model_pred_taken", pred_taken,
                  m_ready ? (m_pht[hash(if1_pc, m_ghr)] >= 2) : 0);
        end
    end

    task automatic drive(bit pv, logic [31:0] pc, bit uv, logic [31:0] upc,
                         logic [7:0] ug, bit ut, bit um);
        pred_valid = pv; if1_pc = pc; upd_valid = uv; upd_pc = upc;
        upd_ghr = ug; upd_taken = ut; upd_mispredict = um;
    endtask

    task automatic apply(bit pv, logic [31:0] pc, bit uv, logic [31:0] upc,
                         logic [7:0] ug, bit ut, bit um);
        drive(pv, pc, uv, upc, ug, ut, um);
        @(posedge clk); #1;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 1), 32'h1C000000 | ($urandom_range(0, 15) << 2),
              $urandom_range(0, 1), 32'h1C000000 | ($urandom_range(0, 15) << 2),
              8'($urandom_range(0, 7)), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
    endtask

    task automatic init_wait(bit randomize, int n, bit check_ready);
        for (int i = 1; i <= n; i++) begin
            if (randomize) drive_random();
            @(posedge clk); #1;
            if (check_ready && (i == 1023 || i == 1024))
                check("init_ready", ready, (i == 1024));
        end
    endtask

    initial begin
        drive(0, '0, 0, '0, '0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        started = 1;
        check("reset_ready", ready, 0);
        check("reset_ghr", pred_ghr, 0);
        check("reset_taken", pred_taken, 0);
        @(posedge clk); #1;

        // bring-up: 1024 init cycles
        rst_n = 1'b1;
        init_wait(0, 1024, 1);
        drive(0, 32'h1C000000, 0, '0, '0, 0, 0); #1;
        check("initial_lookup_taken", pred_taken, 1);

        // train index 4 down and past zero
        apply(0, 32'h1C000010, 1, 32'h1C000010, 8'h00, 0, 0);
        apply(0, 32'h1C000010, 1, 32'h1C000010, 8'h00, 0, 0);
        drive(0, 32'h1C000010, 0, '0, '0, 0, 0); #1;
        check("nt_twice_taken", pred_taken, 0);
        apply(0, 32'h1C000010, 1, 32'h1C000010, 8'h00, 0, 0);
        apply(0, 32'h1C000010, 1, 32'h1C000010, 8'h00, 1, 0);
        drive(0, 32'h1C000010, 0, '0, '0, 0, 0); #1;
        check("floor_then_t_taken", pred_taken, 0);
        apply(0, 32'h1C000010, 1, 32'h1C000010, 8'h00, 1, 0);
        drive(0, 32'h1C000010, 0, '0, '0, 0, 0); #1;
        check("floor_t_t_taken", pred_taken, 1);

        // saturate index 8 at the top
        repeat (3) apply(0, 32'h1C000020, 1, 32'h1C000020, 8'h00, 1, 0);
        apply(0, 32'h1C000020, 1, 32'h1C000020, 8'h00, 0, 0);
        drive(0, 32'h1C000020, 0, '0, '0, 0, 0); #1;
        check("sat_then_nt_taken", pred_taken, 1);
        apply(0, 32'h1C000020, 1, 32'h1C000020, 8'h00, 0, 0);
        drive(0, 32'h1C000020, 0, '0, '0, 0, 0); #1;
        check("sat_nt_nt_taken", pred_taken, 0);

        // speculative history shifting
        drive(1, 32'h1C000000, 0, '0, '0, 0, 0); #1;
        check("spec_ghr_0", pred_ghr, 8'h00);
        @(posedge clk); #2;
        check("spec_ghr_1", pred_ghr, 8'h01);
        @(posedge clk); #2;
        check("spec_ghr_2", pred_ghr, 8'h03);
        @(posedge clk); #1;
        drive(0, 32'h1C000000, 0, '0, '0, 0, 0); #1;
        check("spec_ghr_3", pred_ghr, 8'h07);

        // repair wins over simultaneous lookup
        apply(1, 32'h1C000000, 1, 32'h1C000000, 8'h5A, 1, 1);
        drive(0, 32'h1C000000, 0, '0, '0, 0, 0); #1;
        check("repair_ghr", pred_ghr, 8'hB5);

        // non-mispredict update leaves history alone
        apply(0, 32'h1C000000, 1, 32'h1C000040, 8'h00, 0, 0);
        apply(0, 32'h1C000000, 1, 32'h1C000040, 8'h00, 0, 0);
        drive(0, 32'h1C000294, 0, '0, '0, 0, 0); #1;
        check("no_repair_ghr", pred_ghr, 8'hB5);
        check("trained_16_taken", pred_taken, 0);

        // reset in RUN wins over concurrent update/lookup
        rst_n = 1'b0;
        apply(1, 32'h1C000040, 1, 32'h1C000040, 8'h33, 1, 1);
        rst_n = 1'b1;
        check("rerun_ready", ready, 0);
        check("rerun_ghr", pred_ghr, 0);
        check("rerun_taken", pred_taken, 0);

        // reset again mid-INIT, with noise on the inputs
        init_wait(1, 500, 0);
        rst_n = 1'b0;
        drive_random();
        @(posedge clk); #1;
        rst_n = 1'b1;
        init_wait(1, 1024, 1);
        drive(0, 32'h1C000040, 0, '0, '0, 0, 0); #1;
        check("reinit_16_taken", pred_taken, 1);
        check("reinit_ghr", pred_ghr, 0);

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            @(posedge clk); #1;
        end

        drive(0, '0, 0, '0, '0, 0, 0);
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter GHR_WIDTH, default 8, global history length in bits (legal 2..IDX_WIDTH).
REQ-002 SHALL have parameter IDX_WIDTH, default 10, PHT index width; table depth 2^IDX_WIDTH.
REQ-003 SHALL have parameter CTR_WIDTH, default 2, saturating counter width (legal 2..4).
REQ-004 SHALL use one clock; reset is synchronous and active-low (clk, rst_n).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 pred_valid  input  1  IF1 lookup strobe; advances speculative history.
REQ-008 if1_pc  input  32  IF1 fetch PC.
REQ-009 pred_taken  output  1  prediction for if1_pc.
REQ-010 pred_ghr  output  GHR_WIDTH  speculative history used for this lookup; carried down the pipe.
REQ-011 upd_valid  input  1  EX resolution strobe.
REQ-012 upd_pc  input  32  PC of resolved branch.
REQ-013 upd_ghr  input  GHR_WIDTH  pred_ghr snapshot returned with the resolved branch.
REQ-014 upd_taken  input  1  actual outcome.
REQ-015 upd_mispredict  input  1  direction mispredicted; qualified by upd_valid.
REQ-016 ready  output  1  table initialised; predictions and updates active.

Function
REQ-017 Index SHALL be pc[IDX_WIDTH+1:2] XOR zero-extended GHR (upper IDX_WIDTH-GHR_WIDTH bits unhashed); lookup uses if1_pc/spec_ghr, update uses upd_pc/upd_ghr.
REQ-018 FSM SHALL have states INIT and RUN; INIT writes weakly-taken (MSB=1, rest 0) to one entry per cycle, ascending from 0.
REQ-019 INIT SHALL last exactly 2^IDX_WIDTH cycles, then go to RUN; ready=1 from the first RUN cycle; RUN has no exit except reset.
REQ-020 In INIT: pred_taken=0, spec_ghr held, pred_valid and upd_valid ignored.
REQ-021 In RUN pred_taken SHALL be combinational: MSB of PHT[lookup index]; pred_ghr=spec_ghr regardless of pred_valid.
REQ-022 upd_valid in RUN SHALL update PHT[update index] at the next edge: +1 if upd_taken, -1 if not, saturating at all-ones and 0.
REQ-023 Lookup and update at the same index in the same cycle SHALL see the pre-update value (no bypass).
REQ-024 pred_valid in RUN without repair: spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], pred_taken}.
REQ-025 upd_valid&&upd_mispredict: spec_ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken}; repair SHALL win over a simultaneous pred_valid, whose shift is discarded.
REQ-026 upd_valid without upd_mispredict SHALL not modify spec_ghr.
REQ-027 PHT SHALL be inferable as a single-write-port RAM with asynchronous read; no per-entry reset loop.

Reset
REQ-028 rst_n low at an edge SHALL set state=INIT, init pointer=0, spec_ghr=0, ready=0; pred_taken=0 while not ready.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL restart INIT from entry 0; all prior training lost after re-init.
REQ-030 Reset SHALL take priority over any simultaneous update or lookup.

Verification (defaults: GHR 8, IDX 10, CTR 2)
REQ-031 Release rst_n -> ready=0 for 1024 cycles, 1 on cycle 1025; lookup pc=0x1C000000 -> pred_taken=1.
REQ-032 Two upd_valid, upd_taken=0, pc=0x1C000010, ghr=0x00 -> counter 10->01->00; lookup same pc, spec_ghr 0 -> 0; third NT stays 00.
REQ-033 Three taken updates same entry -> saturate 11; one NT -> 10, pred_taken stays 1.
REQ-034 From spec_ghr=0x00, three pred_valid cycles predicting taken -> pred_ghr 0x00,0x01,0x03, then spec_ghr=0x07.
REQ-035 upd_mispredict with upd_ghr=0x5A, upd_taken=1, same cycle as pred_valid -> spec_ghr=0xB5 next cycle.
REQ-036 Train entry to 00, pulse rst_n low 1 cycle in RUN -> ready=0 next cycle, 1024-cycle re-init, entry reads taken afterwards.
